// File: rtl/fifo_ram.sv
// Storage array for stream_fifo: DEPTH x DATA_WIDTH registers, one write port, async read port.
// Latency: write lands at the clock edge; read data follows rdAddr combinationally.
// Backpressure: none; the owner decides when writes are allowed.
// Ports: clk; wrEn/wrAddr/wrData write port; rdAddr/rdData asynchronous read port.
module fifo_ram #(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_W     = 4,
    parameter int DEPTH      = 1 << ADDR_W
) (
    input  logic                  clk,
    input  logic                  wrEn,
    input  logic [ADDR_W-1:0]     wrAddr,
    input  logic [DATA_WIDTH-1:0] wrData,
    input  logic [ADDR_W-1:0]     rdAddr,
    output logic [DATA_WIDTH-1:0] rdData
);

    // Contents are deliberately not reset; pointers alone define validity.
    logic [DATA_WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (wrEn) begin
            mem[wrAddr] <= wrData;
        end
    end

    assign rdData = mem[rdAddr];

endmodule

// File: rtl/stream_fifo.sv
// Parametrised synchronous stream FIFO with count, almost flags, sticky errors and flush.
// Latency: writeAck 1 cycle; read 1 cycle (FWFT=0) or head word visible combinationally (FWFT=1).
// Backpressure: push refused when full unless a pop is accepted in the same cycle; pop refused when empty.
// Ports: clk, rstN (async active-low), flush; writeReq/dataIn/writeAck push side;
//        readReq/readAck/dataOut pop side; empty/full/count/almostFull/almostEmpty status;
//        overflow/underflow sticky errors cleared by clearErr.
module stream_fifo #(
    parameter int DATA_WIDTH      = 16,
    parameter int FIFO_LOG_LENGTH = 4,
    parameter int AFULL_LEVEL     = (1 << FIFO_LOG_LENGTH) - 2,
    parameter int AEMPTY_LEVEL    = 2,
    parameter int FWFT            = 0
) (
    input  logic                       clk,
    input  logic                       rstN,
    input  logic                       flush,
    input  logic                       writeReq,
    input  logic [DATA_WIDTH-1:0]      dataIn,
    output logic                       writeAck,
    input  logic                       readReq,
    output logic                       readAck,
    output logic [DATA_WIDTH-1:0]      dataOut,
    output logic                       empty,
    output logic                       full,
    output logic [FIFO_LOG_LENGTH:0]   count,
    output logic                       almostFull,
    output logic                       almostEmpty,
    output logic                       overflow,
    output logic                       underflow,
    input  logic                       clearErr
);

    localparam int DEPTH = 1 << FIFO_LOG_LENGTH;
    localparam int PTR_W = FIFO_LOG_LENGTH + 1;
    localparam logic [PTR_W-1:0] AFULL_CNT  = PTR_W'(AFULL_LEVEL);
    localparam logic [PTR_W-1:0] AEMPTY_CNT = PTR_W'(AEMPTY_LEVEL);

    // Extra MSB on each pointer distinguishes full from empty, so every slot is usable.
    logic [PTR_W-1:0]      putPtr;
    logic [PTR_W-1:0]      getPtr;
    logic                  popAccepted;
    logic                  pushAccepted;
    logic [DATA_WIDTH-1:0] headData;

    assign empty = (putPtr == getPtr);
    assign full  = (putPtr[FIFO_LOG_LENGTH-1:0] == getPtr[FIFO_LOG_LENGTH-1:0]) &&
                   (putPtr[FIFO_LOG_LENGTH] != getPtr[FIFO_LOG_LENGTH]);
    assign count       = putPtr - getPtr;
    assign almostFull  = (count >= AFULL_CNT);
    assign almostEmpty = (count <= AEMPTY_CNT);

    // Flush overrides any traffic in the same cycle, including error detection.
    assign popAccepted  = readReq && !empty && !flush;
    assign pushAccepted = writeReq && (!full || popAccepted) && !flush;

    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            putPtr   <= '0;
            getPtr   <= '0;
            writeAck <= 1'b0;
        end else if (flush) begin
            putPtr   <= '0;
            getPtr   <= '0;
            writeAck <= 1'b0;
        end else begin
            writeAck <= pushAccepted;
            if (pushAccepted) putPtr <= putPtr + 1'b1;
            if (popAccepted)  getPtr <= getPtr + 1'b1;
        end
    end

    // Sticky errors: a new error event wins over a simultaneous clearErr.
    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            if (writeReq && full && !popAccepted && !flush) overflow <= 1'b1;
            else if (clearErr)                               overflow <= 1'b0;
            if (readReq && empty && !flush)                  underflow <= 1'b1;
            else if (clearErr)                               underflow <= 1'b0;
        end
    end

    fifo_ram #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_W     (FIFO_LOG_LENGTH),
        .DEPTH      (DEPTH)
    ) uRam (
        .clk    (clk),
        .wrEn   (pushAccepted),
        .wrAddr (putPtr[FIFO_LOG_LENGTH-1:0]),
        .wrData (dataIn),
        .rdAddr (getPtr[FIFO_LOG_LENGTH-1:0]),
        .rdData (headData)
    );

    generate
        if (FWFT != 0) begin : gFwft
            // Head word is presented directly; the pop retires it at the acking edge.
            assign readAck = popAccepted;
            assign dataOut = headData;
        end else begin : gReg
            logic                  readAckReg;
            logic [DATA_WIDTH-1:0] dataOutReg;

            always_ff @(posedge clk or negedge rstN) begin
                if (!rstN) begin
                    readAckReg <= 1'b0;
                    dataOutReg <= '0;
                end else if (flush) begin
                    readAckReg <= 1'b0;
                end else begin
                    readAckReg <= popAccepted;
                    if (popAccepted) dataOutReg <= headData;
                end
            end

            assign readAck = readAckReg;
            assign dataOut = dataOutReg;
        end
    endgenerate

endmodule

// File: tb/tb_stream_fifo.sv
module tb_stream_fifo;

    logic       clk = 1'b0;
    logic       rstN;
    always #5 clk = ~clk;

    // Registered-read instance
    logic       flush, writeReq, readReq, clearErr;
    logic [7:0] dataIn;
    logic       writeAck, readAck, empty, full, almostFull, almostEmpty, overflow, underflow;
    logic [7:0] dataOut;
    logic [2:0] count;

    // FWFT instance
    logic       fFlush, fWriteReq, fReadReq, fClearErr;
    logic [7:0] fDataIn;
    logic       fWriteAck, fReadAck, fEmpty, fFull, fAlmostFull, fAlmostEmpty, fOverflow, fUnderflow;
    logic [7:0] fDataOut;
    logic [2:0] fCount;

    stream_fifo #(.DATA_WIDTH(8), .FIFO_LOG_LENGTH(2), .AFULL_LEVEL(3), .AEMPTY_LEVEL(1), .FWFT(0)) dut (
        .clk(clk), .rstN(rstN), .flush(flush),
        .writeReq(writeReq), .dataIn(dataIn), .writeAck(writeAck),
        .readReq(readReq), .readAck(readAck), .dataOut(dataOut),
        .empty(empty), .full(full), .count(count),
        .almostFull(almostFull), .almostEmpty(almostEmpty),
        .overflow(overflow), .underflow(underflow), .clearErr(clearErr)
    );

    stream_fifo #(.DATA_WIDTH(8), .FIFO_LOG_LENGTH(2), .AFULL_LEVEL(3), .AEMPTY_LEVEL(1), .FWFT(1)) dutF (
        .clk(clk), .rstN(rstN), .flush(fFlush),
        .writeReq(fWriteReq), .dataIn(fDataIn), .writeAck(fWriteAck),
        .readReq(fReadReq), .readAck(fReadAck), .dataOut(fDataOut),
        .empty(fEmpty), .full(fFull), .count(fCount),
        .almostFull(fAlmostFull), .almostEmpty(fAlmostEmpty),
        .overflow(fOverflow), .underflow(fUnderflow), .clearErr(fClearErr)
    );

    int vecCnt = 0;
    int errCnt = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vecCnt++;
        if (obs !== exp) begin
            errCnt++;
            $display("FAIL %s: got 0x%0h, want 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Reference model state for the registered-read instance
    logic [7:0] sb[$];
    logic       mOvf = 1'b0;
    logic       mUnf = 1'b0;
    logic [7:0] lastOut = 8'h00;

    task automatic checkResetOutputs();
        chk("rst_empty", empty, 1);
        chk("rst_full", full, 0);
        chk("rst_count", count, 0);
        chk("rst_aempty", almostEmpty, 1);
        chk("rst_afull", almostFull, 0);
        chk("rst_wack", writeAck, 0);
        chk("rst_rack", readAck, 0);
        chk("rst_ovf", overflow, 0);
        chk("rst_unf", underflow, 0);
        chk("rst_dout", dataOut, 0);
        chk("rst_f_empty", fEmpty, 1);
        chk("rst_f_count", fCount, 0);
    endtask

    // One clock of traffic on the registered instance; inputs are applied at posedge+1,
    // outputs checked at the following posedge+1 against the model.
    task automatic step(input logic w, input logic r, input logic [7:0] d,
                        input logic fl, input logic clr, input string tag);
        logic mEmpty, mFull, popA, pushA;
        logic [7:0] exp;
        writeReq = w; readReq = r; dataIn = d; flush = fl; clearErr = clr;
        mEmpty = (sb.size() == 0);
        mFull  = (sb.size() == 4);
        popA   = r && !mEmpty && !fl;
        pushA  = w && (!mFull || popA) && !fl;
        if (w && mFull && !popA && !fl) mOvf = 1'b1;
        else if (clr)                   mOvf = 1'b0;
        if (r && mEmpty && !fl)         mUnf = 1'b1;
        else if (clr)                   mUnf = 1'b0;
        @(posedge clk);
        #1;
        writeReq = 0; readReq = 0; flush = 0; clearErr = 0;
        if (popA) lastOut = sb.pop_front();
        if (pushA) sb.push_back(d);
        if (fl) sb.delete();
        exp = lastOut;
        chk({tag, "_wack"}, writeAck, pushA);
        chk({tag, "_rack"}, readAck, popA);
        chk({tag, "_dout"}, dataOut, exp);
        chk({tag, "_count"}, count, sb.size());
        chk({tag, "_empty"}, empty, sb.size() == 0);
        chk({tag, "_full"}, full, sb.size() == 4);
        chk({tag, "_afull"}, almostFull, sb.size() >= 3);
        chk({tag, "_aempty"}, almostEmpty, sb.size() <= 1);
        chk({tag, "_ovf"}, overflow, mOvf);
        chk({tag, "_unf"}, underflow, mUnf);
    endtask

    initial begin
        logic [7:0] fill [4] = '{8'h11, 8'h22, 8'h33, 8'h44};
        rstN = 1'b0;
        flush = 0; writeReq = 0; readReq = 0; clearErr = 0; dataIn = 0;
        fFlush = 0; fWriteReq = 0; fReadReq = 0; fClearErr = 0; fDataIn = 0;
        #3;
        checkResetOutputs();
        #4 rstN = 1'b1;
        @(posedge clk); #1;

        // Fill to full, then an overflowing write
        for (int i = 0; i < 4; i++) step(1, 0, fill[i], 0, 0, "fill");
        step(1, 0, 8'h55, 0, 0, "ovfwr");

        // Drain in order, then an underflowing read (dataOut must hold 0x44)
        for (int i = 0; i < 4; i++) step(0, 1, 8'h00, 0, 0, "drain");
        step(0, 1, 8'h00, 0, 0, "unfrd");

        // Clear sticky errors
        step(0, 0, 8'h00, 0, 1, "clrerr");

        // Refill, simultaneous push+pop while full, drain across the wrap
        for (int i = 0; i < 4; i++) step(1, 0, fill[i], 0, 0, "refill");
        step(1, 1, 8'h66, 0, 0, "fullrw");
        for (int i = 0; i < 4; i++) step(0, 1, 8'h00, 0, 0, "wrapdrain");

        // Push+pop while empty: push only, underflow set
        step(1, 1, 8'h77, 0, 0, "emptyrw");
        step(0, 1, 8'h00, 0, 0, "get77");

        // Overflow once so flush can be shown to preserve it
        for (int i = 0; i < 4; i++) step(1, 0, fill[i], 0, 0, "fill2");
        step(1, 0, 8'h99, 0, 0, "ovf2");
        step(0, 1, 8'h00, 0, 0, "to3");
        step(1, 0, 8'hAA, 1, 0, "flushwr");
        step(1, 0, 8'hBB, 0, 0, "postflush");
        step(0, 1, 8'h00, 0, 0, "getBB");

        // Reset mid-stream: outputs drop without a clock edge
        step(1, 0, 8'hC1, 0, 0, "prerst");
        step(1, 0, 8'hC2, 0, 0, "prerst");
        writeReq = 1; dataIn = 8'hC3;
        rstN = 1'b0;
        #2;
        checkResetOutputs();
        writeReq = 0;
        sb.delete(); mOvf = 0; mUnf = 0; lastOut = 8'h00;
        #1 rstN = 1'b1;
        @(posedge clk); #1;
        step(1, 0, 8'hD4, 0, 0, "postrst");
        step(0, 1, 8'h00, 0, 0, "getD4");

        // FWFT instance
        fWriteReq = 1; fDataIn = 8'hA5;
        @(posedge clk); #1;
        fWriteReq = 0;
        chk("fwft_wack", fWriteAck, 1);
        chk("fwft_head", fDataOut, 8'hA5);
        chk("fwft_notempty", fEmpty, 0);
        fReadReq = 1;
        #1;
        chk("fwft_rack_comb", fReadAck, 1);
        @(posedge clk); #1;
        fReadReq = 0;
        chk("fwft_empty_after", fEmpty, 1);
        chk("fwft_rack_idle", fReadAck, 0);
        fWriteReq = 1; fDataIn = 8'hB1;
        @(posedge clk); #1;
        fDataIn = 8'hB2;
        @(posedge clk); #1;
        fWriteReq = 0;
        chk("fwft_count2", fCount, 2);
        chk("fwft_head_b1", fDataOut, 8'hB1);
        fReadReq = 1;
        @(posedge clk); #1;
        chk("fwft_head_b2", fDataOut, 8'hB2);
        chk("fwft_rack_b2", fReadAck, 1);
        @(posedge clk); #1;
        fReadReq = 1;
        #1;
        chk("fwft_rack_empty", fReadAck, 0);
        @(posedge clk); #1;
        fReadReq = 0;
        chk("fwft_unf", fUnderflow, 1);

        $display("== %0d vectors applied, %0d miscompares ==", vecCnt, errCnt);
        $finish;
    end

endmodule

// File: doc/stream_fifo.md
Name: stream_fifo

Overview:
Parametrised synchronous FIFO that replaces the fixed 16x16 UART buffer for the TX and RX paths. It uses all 2^FIFO_LOG_LENGTH slots, because the pointers carry an extra wrap bit. It adds an occupancy count, programmable almost-full/almost-empty flags, sticky overflow/underflow error flags and a synchronous flush. A mode parameter selects a registered-read or first-word-fall-through (FWFT) read port.

Parameters:
DATA_WIDTH, 16, word width in bits (>=1)
FIFO_LOG_LENGTH, 4, log2 of depth; DEPTH = 1<<FIFO_LOG_LENGTH (>=1)
AFULL_LEVEL, DEPTH-2, almostFull asserted when count >= AFULL_LEVEL
AEMPTY_LEVEL, 2, almostEmpty asserted when count <= AEMPTY_LEVEL
FWFT, 0, 0 = registered read, 1 = first-word-fall-through

Ports:
clk  input  1  clock; all logic on rising edge
rstN  input  1  asynchronous active-low reset
flush  input  1  synchronous clear of contents and pointers
writeReq  input  1  push request
dataIn  input  DATA_WIDTH  push data
writeAck  output  1  registered; 1 the cycle after an accepted push
readReq  input  1  pop request
readAck  output  1  FWFT=0: registered, 1 the cycle after an accepted pop; FWFT=1: combinational, readReq & !empty
dataOut  output  DATA_WIDTH  FWFT=0: registered popped word; FWFT=1: head word while !empty
empty  output  1  count == 0
full  output  1  count == DEPTH
count  output  FIFO_LOG_LENGTH+1  occupancy, 0..DEPTH
almostFull  output  1  count >= AFULL_LEVEL
almostEmpty  output  1  count <= AEMPTY_LEVEL
overflow  output  1  sticky; set by a write request while full and not popping
underflow  output  1  sticky; set by a read request while empty
clearErr  input  1  synchronous clear of overflow and underflow

Behaviour:
- Reset (rstN low, asynchronous): pointers, count, writeAck, readAck (FWFT=0), dataOut register, overflow and underflow all go to 0. Outputs then read empty=1, full=0, almostEmpty=1, almostFull=(AFULL_LEVEL==0). Buffer contents are not reset.
- Pointers are FIFO_LOG_LENGTH+1 bits wide, and the low bits index the buffer.
- empty: pointers are equal. full: low bits are equal and MSBs differ. count = putPtr - getPtr, modulo 2^(FIFO_LOG_LENGTH+1).
- Push accepted when writeReq & (!full | popAccepted). Pop accepted when readReq & !empty.
- Simultaneous push and pop when full: both are accepted and count is unchanged.
- Simultaneous push and pop when empty: only the push is accepted; underflow is set.
- Rejected push: buffer unchanged, writeAck=0 next cycle, overflow set.
- Rejected pop: readAck=0, dataOut holds its value, underflow set.
- FWFT=0: latency is 1 cycle. On an accepted pop, dataOut <= buffer[getPtr] and readAck=1 in the next cycle. dataOut holds between pops.
- FWFT=1: dataOut = buffer[getPtr] combinationally. A pushed word is visible on dataOut the cycle after its push edge. The pop takes effect at the edge where readAck is 1. dataOut is don't-care while empty.
- writeAck is always registered, one cycle after the accepting edge.
- flush: at the edge, pointers go to 0 and acks go to 0. Any push or pop in the same cycle is ignored and raises no error flags. overflow and underflow are preserved.
- Error flags: set has priority over clearErr in the same cycle.
- Wrap-around: pointers wrap naturally. A full DEPTH of writes followed by DEPTH reads returns the data in order across the wrap.
- Reset mid-operation: the FIFO becomes empty immediately; in-flight acks are dropped.

Decomposition:
- No shared package is required. Derived localparams (DEPTH, PTR_W = FIFO_LOG_LENGTH+1) stay local.
- One sub-module, fifo_ram: DEPTH x DATA_WIDTH register array with a write port and an asynchronous read port.
- Pointer, count, flag and ack logic stay in stream_fifo.

Test Plan (all scenarios use DATA_WIDTH=8, FIFO_LOG_LENGTH=2 so DEPTH=4, AFULL_LEVEL=3, AEMPTY_LEVEL=1, FWFT=0 unless noted):
- Reset then idle -> empty=1, count=0, almostEmpty=1, full=0, all acks and flags 0.
- Write 0x11,0x22,0x33,0x44 -> count 1..4 with writeAck each cycle; almostFull from count=3; full=1 at 4. A fifth write 0x55 -> writeAck=0, overflow=1, contents unchanged.
- Read four times from full -> dataOut 0x11,0x22,0x33,0x44 one cycle after each readReq. A fifth readReq -> readAck=0, underflow=1, dataOut stays 0x44.
- While full, readReq+writeReq with 0x66 -> both acked, count stays 4, no overflow. Drain -> 0x22,0x33,0x44,0x66 (wrap verified).
- FWFT=1: write 0xA5 -> the next cycle dataOut=0xA5 with empty=0. readReq -> readAck=1 in the same cycle, empty=1 after the edge.
- With count=3, assert flush together with writeReq -> count=0, empty=1, no writeAck, overflow unchanged. Drop rstN mid-stream -> outputs at reset values immediately, with no clock edge.
